// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding,
// instruction size and the default reset vector.
package pc_sequencer_pkg;

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_DEC = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC, runs the instruction-memory
// request/ack handshake and applies branch/JALR redirects.
//
// Handshake: imem_req is high exactly while the FSM is in REQ. A fetch is
// accepted in the cycle imem_req && imem_ack; imem_addr only changes on that
// acceptance or while no request is pending, so it is stable until acked.
// At most one request is ever outstanding.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_imm,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] adder_pc,
  output logic [XLEN-1:0] adder_imm,
  input  logic [XLEN-1:0] adder_result,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            flush,
  output logic            misalign_err
);

  logic [1:0]      state;
  logic [XLEN-1:0] pend_target;
  logic            pend_valid;
  logic            discard;

  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            redir_live;
  logic            redir_ok;
  logic            redir_bad;
  logic            acked;
  logic            deliver;

  // The branch adder lives outside this block; feed it straight from EX.
  assign adder_pc  = branch_pc;
  assign adder_imm = branch_imm;

  assign imem_req = (state == ST_REQ);
  assign acked    = imem_req && imem_ack;

  // Pick the redirect source: JALR has priority over a taken branch.
  always_comb begin
    redir_valid  = 1'b0;
    redir_target = '0;
    if (jalr_valid) begin
      redir_valid  = 1'b1;
      redir_target = jalr_target;
    end else if (branch_valid && branch_taken) begin
      redir_valid  = 1'b1;
      redir_target = adder_result;
    end
  end

  // Once a misaligned target has been seen, all further redirects are ignored.
  assign redir_live = redir_valid && !misalign_err && (state != ST_HALT);
  assign redir_ok   = redir_live && (redir_target[1:0] == 2'b00);
  assign redir_bad  = redir_live && (redir_target[1:0] != 2'b00);

  // An ack is forwarded to decode unless it belongs to a stale (redirected) fetch.
  assign deliver = acked && !discard && !redir_live && !misalign_err;

  // Fetch FSM, request address and pending-redirect bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      imem_addr   <= RESET_VECTOR;
      pend_target <= '0;
      pend_valid  <= 1'b0;
      discard     <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (redir_bad) begin
            state <= ST_HALT;
          end else begin
            state <= ST_REQ;
            if (redir_ok) imem_addr <= redir_target;
          end
        end
        ST_REQ: begin
          if (!imem_ack) begin
            // Request still in flight: remember the target and drop the return.
            if (redir_ok) begin
              pend_target <= redir_target;
              pend_valid  <= 1'b1;
              discard     <= 1'b1;
            end else if (redir_bad) begin
              discard <= 1'b1;
            end
          end else begin
            discard    <= 1'b0;
            pend_valid <= 1'b0;
            if (misalign_err || redir_bad) begin
              state <= ST_HALT;
            end else if (redir_ok) begin
              imem_addr <= redir_target;
            end else if (pend_valid) begin
              imem_addr <= pend_target;
            end else begin
              // Sequential fetch; wraps past the top of the address space.
              imem_addr <= imem_addr + XLEN'(INSTR_BYTES);
              state     <= stall ? ST_WAIT_DEC : ST_REQ;
            end
          end
        end
        ST_WAIT_DEC: begin
          if (redir_bad) begin
            state <= ST_HALT;
          end else if (redir_ok) begin
            imem_addr <= redir_target;
            state     <= ST_REQ;
          end else if (!stall) begin
            state <= ST_REQ;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Instruction handed to decode, held while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
    end else if (deliver) begin
      fetch_valid <= 1'b1;
      fetch_pc    <= imem_addr;
    end else if (redir_ok || !stall) begin
      fetch_valid <= 1'b0;
    end
  end

  // Flush pulse on an accepted redirect; sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      flush        <= redir_ok;
      misalign_err <= misalign_err | redir_bad;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus a randomized phase,
// checked every cycle against a transaction-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [31:0] branch_imm = '0;
  logic        jalr_valid = 1'b0;
  logic [31:0] jalr_target = '0;
  logic [31:0] adder_pc;
  logic [31:0] adder_imm;
  logic [31:0] adder_result;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        misalign_err;

  // Stand-in for the sibling adder_branch instance.
  assign adder_result = adder_pc + adder_imm;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .stall(stall),
    .branch_valid(branch_valid), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_imm(branch_imm),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .adder_pc(adder_pc), .adder_imm(adder_imm), .adder_result(adder_result),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .flush(flush), .misalign_err(misalign_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks: address of the current/next fetch, whether a request is on the
  // bus, whether the in-flight return is stale, and a remembered redirect.
  bit          m_req, m_boot, m_fv, m_flush, m_err, m_drop, m_pendv, m_new;
  logic [31:0] m_addr, m_fpc, m_pend;

  task automatic model_reset();
    m_req = 0; m_boot = 1; m_fv = 0; m_flush = 0; m_err = 0;
    m_drop = 0; m_pendv = 0; m_new = 0;
    m_addr = RV; m_fpc = '0; m_pend = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit ack_in, input bit stall_in, input bit rv,
                            input logic [31:0] rt);
    bit live, good, bad, done;
    live = rv && !m_err;
    good = live && (rt % 4 == 0);
    bad  = live && !good;
    done = m_req && ack_in;
    m_new = done && !m_drop && !live && !m_err;
    m_flush = good;
    if (m_new) begin
      m_fv = 1; m_fpc = m_addr; exp_q.push_back(m_addr);
    end else if (good || !stall_in) begin
      m_fv = 0;
    end
    if (m_req && !done) begin
      if (good) begin m_pend = rt; m_pendv = 1; m_drop = 1; end
      else if (bad) m_drop = 1;
    end else begin
      if (m_err || bad)            m_req = 0;
      else if (good)               begin m_addr = rt; m_req = 1; end
      else if (done && m_pendv)    begin m_addr = m_pend; m_req = 1; end
      else if (done)               begin m_addr = m_addr + 4; m_req = !stall_in; end
      else                         m_req = m_boot || !stall_in;
      m_drop = 0; m_pendv = 0; m_boot = 0;
    end
    if (bad) m_err = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] imm, input bit taken);
    branch_valid = 1'b1; branch_taken = taken; branch_pc = pc; branch_imm = imm;
  endtask

  task automatic drive_jalr(input logic [31:0] target);
    jalr_valid = 1'b1; jalr_target = target;
  endtask

  task automatic check_outputs();
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_addr);
    chk("fetch_valid", fetch_valid, m_fv);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("flush", flush, m_flush);
    chk("misalign_err", misalign_err, m_err);
    if (m_new) chk("sb_fetch_pc", fetch_pc, exp_q.pop_front());
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic cycle(input bit ack_in, input bit stall_in);
    bit rv;
    logic [31:0] rt;
    imem_ack = ack_in;
    stall    = stall_in;
    #1;
    chk("adder_pc", adder_pc, branch_pc);
    chk("adder_imm", adder_imm, branch_imm);
    rv = jalr_valid || (branch_valid && branch_taken);
    rt = jalr_valid ? jalr_target : (branch_pc + branch_imm);
    model_step(ack_in, stall_in, rv, rt);
    @(posedge clk);
    #1;
    check_outputs();
    branch_valid = 1'b0;
    branch_taken = 1'b0;
    jalr_valid   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_req"}, imem_req, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, RV);
    chk({tag, "_fetch_valid"}, fetch_valid, 1'b0);
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_misalign_err"}, misalign_err, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch, ack every cycle.
    cycle(0, 0);
    chk("boot_req", imem_req, 1'b1);
    chk("boot_addr", imem_addr, 32'h0);
    cycle(1, 0);
    chk("seq_fpc0", fetch_pc, 32'h0);
    chk("seq_addr4", imem_addr, 32'h4);
    cycle(1, 0);
    chk("seq_fpc4", fetch_pc, 32'h4);

    // Ack delayed three cycles at 0x8.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0);
      chk("hold_addr8", imem_addr, 32'h8);
    end
    cycle(1, 0);
    chk("late_fv", fetch_valid, 1'b1);
    chk("late_fpc8", fetch_pc, 32'h8);

    // Ack 0xC with stall: no new request; then a branch while idle.
    cycle(1, 1);
    chk("stall_req", imem_req, 1'b0);
    drive_branch(32'h100, 32'hFFFF_FFF0, 1'b1);
    cycle(0, 1);
    chk("br_flush", flush, 1'b1);
    chk("br_addr", imem_addr, 32'hF0);
    chk("br_fv", fetch_valid, 1'b0);
    cycle(0, 0);
    chk("br_flush_end", flush, 1'b0);
    cycle(1, 0);

    // Redirect while 0xF4 is outstanding: its return is dropped.
    drive_branch(32'h1F0, 32'h10, 1'b1);
    cycle(0, 0);
    chk("pend_addr_hold", imem_addr, 32'hF4);
    cycle(0, 0);
    cycle(1, 0);
    chk("pend_drop_fv", fetch_valid, 1'b0);
    chk("pend_addr", imem_addr, 32'h200);

    // JALR and taken branch together, coinciding with an ack.
    drive_jalr(32'h400);
    drive_branch(32'h300, 32'h0, 1'b1);
    cycle(1, 0);
    chk("jalr_flush", flush, 1'b1);
    chk("jalr_addr", imem_addr, 32'h400);
    cycle(0, 0);
    chk("jalr_single_flush", flush, 1'b0);

    // Address wrap at the top of memory.
    cycle(1, 0);
    drive_jalr(32'hFFFF_FFFC);
    cycle(1, 0);
    cycle(1, 0);
    chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_no_err", misalign_err, 1'b0);

    // Randomized traffic with aligned redirects.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        drive_branch($urandom & 32'hFFFF_FFFC,
                     32'($urandom_range(0, 255)) * 32'd4 - 32'd512,
                     1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0)
        drive_jalr($urandom & 32'hFFFF_FFFC);
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    cycle(0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // An ack while booting is ignored.
    cycle(1, 0);
    chk("boot_ack_fv", fetch_valid, 1'b0);
    chk("boot_ack_addr", imem_addr, RV);
    cycle(1, 0);
    chk("restart_fpc", fetch_pc, RV);

    // Misaligned JALR while a fetch is outstanding.
    drive_jalr(32'h402);
    cycle(0, 0);
    chk("mis_err", misalign_err, 1'b1);
    chk("mis_no_flush", flush, 1'b0);
    cycle(1, 0);
    chk("mis_req_off", imem_req, 1'b0);
    drive_jalr(32'h800);
    cycle(1, 0);
    cycle(0, 0);
    chk("halt_req_off", imem_req, 1'b0);
    chk("halt_err_sticky", misalign_err, 1'b1);

    // Reset leaves HALT and restarts at the reset vector.
    do_reset();
    cycle(0, 0);
    chk("post_halt_req", imem_req, 1'b1);
    chk("post_halt_addr", imem_addr, RV);
    cycle(1, 0);
    chk("post_halt_fpc", fetch_pc, RV);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
